multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences each instruction through

---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/ctrl_decode.sv | 33 +++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the RV32I multi-cycle control FSM
//   state_e      FSM states
//   opclass_e    instruction class latched in DECODE
//   OPC_*        RV32I major opcodes
//   IMM_*        one-hot immediate-type selects {J,U,B,S,I}
//   ALU_*/PC_*/WB_*/CAUSE_*  datapath mux and trap encodings
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_e;

    typedef enum logic [3:0] {
        CL_OP,
        CL_OP_IMM,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR
    } opclass_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] IMM_NONE = 5'b00000;
    localparam logic [4:0] IMM_I    = 5'b00001;
    localparam logic [4:0] IMM_S    = 5'b00010;
    localparam logic [4:0] IMM_B    = 5'b00100;
    localparam logic [4:0] IMM_U    = 5'b01000;
    localparam logic [4:0] IMM_J    = 5'b10000;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_FUNCT = 2'd1;
    localparam logic [1:0] ALU_CMP   = 2'd2;
    localparam logic [1:0] ALU_PASSB = 2'd3;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_RS1   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic [4:0] imm_of(input opclass_e c);
        return (c == CL_OP_IMM || c == CL_LOAD || c == CL_JALR) ? IMM_I :
               (c == CL_STORE)                                 ? IMM_S :
               (c == CL_BRANCH)                                ? IMM_B :
               (c == CL_LUI || c == CL_AUIPC)                  ? IMM_U :
               (c == CL_JAL)                                   ? IMM_J : IMM_NONE;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I opcode classifier
//   opcode    in   7  instruction bits [6:0]
//   cls       out  4  instruction class
//   imm_type  out  5  one-hot immediate type for that class (0 when illegal)
//   legal     out  1  opcode is one of the supported RV32I major opcodes
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_e   cls,
    output logic [4:0] imm_type,
    output logic       legal
);

    always_comb begin
        cls   = CL_OP;
        legal = 1'b1;
        case (opcode)
            OPC_OP:     cls = CL_OP;
            OPC_OP_IMM: cls = CL_OP_IMM;
            OPC_LOAD:   cls = CL_LOAD;
            OPC_STORE:  cls = CL_STORE;
            OPC_BRANCH: cls = CL_BRANCH;
            OPC_LUI:    cls = CL_LUI;
            OPC_AUIPC:  cls = CL_AUIPC;
            OPC_JAL:    cls = CL_JAL;
            OPC_JALR:   cls = CL_JALR;
            default:    legal = 1'b0;
        endcase
        imm_type = legal ? imm_of(cls) : IMM_NONE;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core
//   iClk, iRst (async, active-high)
//   iInstruction  IR contents; iMem_ready memory ack; iBr_taken branch result (EXEC)
//   oImm_type     one-hot {J,U,B,S,I} immediate select
//   oIR_we, oPC_we, oPC_sel           instruction/PC register strobes
//   oMem_req, oMem_we, oMem_addr_sel  memory request handshake
//   oALU_srcA, oALU_srcB, oALU_op     ALU operand muxes and operation
//   oReg_we, oWb_sel                  register-file write-back
//   oTrap, oCause                     sticky halt flag and its cause
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iInstruction,
    input  logic        iMem_ready,
    input  logic        iBr_taken,
    output logic [4:0]  oImm_type,
    output logic        oIR_we,
    output logic        oPC_we,
    output logic [1:0]  oPC_sel,
    output logic        oMem_req,
    output logic        oMem_we,
    output logic        oMem_addr_sel,
    output logic        oALU_srcA,
    output logic        oALU_srcB,
    output logic [1:0]  oALU_op,
    output logic        oReg_we,
    output logic [1:0]  oWb_sel,
    output logic        oTrap,
    output logic [1:0]  oCause
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    state_e         state, state_n;
    opclass_e       cls_q, dec_cls;
    logic [4:0]     imm_q, dec_imm;
    logic           dec_legal;
    logic [CW-1:0]  wait_cnt, wait_cnt_n;
    logic [1:0]     cause_q, cause_n;
    logic           req_state, timeout;
    logic           unused_instr;

    // Only the major opcode steers control; funct fields go straight to the ALU.
    assign unused_instr = ^iInstruction[31:7];

    ctrl_decode u_decode (
        .opcode   (iInstruction[6:0]),
        .cls      (dec_cls),
        .imm_type (dec_imm),
        .legal    (dec_legal)
    );

    assign req_state = state == FETCH || state == MEM;
    // A ready arriving on the final allowed cycle still completes the request.
    assign timeout   = req_state && !iMem_ready && wait_cnt == WAIT_LAST;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= FETCH;
            cls_q    <= CL_OP;
            imm_q    <= IMM_NONE;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            cause_q  <= cause_n;
            if (state == DECODE) begin
                cls_q <= dec_cls;
                imm_q <= dec_imm;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            FETCH:  state_n = iMem_ready ? DECODE : timeout ? TRAP : FETCH;
            DECODE: state_n = dec_legal ? EXEC : TRAP;
            EXEC:   state_n = (cls_q == CL_LOAD || cls_q == CL_STORE) ? MEM :
                              (cls_q == CL_BRANCH) ? FETCH : WB;
            MEM:    state_n = iMem_ready ? (cls_q == CL_LOAD ? WB : FETCH) :
                              timeout ? TRAP : MEM;
            WB:     state_n = FETCH;
            default: state_n = TRAP;
        endcase
        cause_n    = (state == DECODE && !dec_legal) ? CAUSE_ILLEGAL :
                     timeout ? CAUSE_TIMEOUT : cause_q;
        wait_cnt_n = (req_state && !iMem_ready && state_n == state) ? wait_cnt + 1'b1 : '0;
    end

    // Strobes are forced low for the whole reset window, including the
    // FETCH request the reset state would otherwise raise.
    always_comb begin
        oImm_type     = IMM_NONE;
        oIR_we        = 1'b0;
        oPC_we        = 1'b0;
        oPC_sel       = PC_PLUS4;
        oMem_req      = 1'b0;
        oMem_we       = 1'b0;
        oMem_addr_sel = 1'b0;
        oALU_srcA     = 1'b0;
        oALU_srcB     = 1'b0;
        oALU_op       = ALU_ADD;
        oReg_we       = 1'b0;
        oWb_sel       = WB_ALU;
        oTrap         = 1'b0;
        oCause        = CAUSE_NONE;
        if (!iRst) begin
            oTrap  = state == TRAP;
            oCause = cause_q;
            case (state)
                FETCH: begin
                    oMem_req = 1'b1;
                    oIR_we   = iMem_ready;
                end
                EXEC: begin
                    oImm_type = imm_q;
                    oALU_srcA = cls_q == CL_AUIPC || cls_q == CL_JAL;
                    oALU_srcB = !(cls_q == CL_OP || cls_q == CL_BRANCH);
                    oALU_op   = (cls_q == CL_OP || cls_q == CL_OP_IMM) ? ALU_FUNCT :
                                (cls_q == CL_BRANCH) ? ALU_CMP :
                                (cls_q == CL_LUI) ? ALU_PASSB : ALU_ADD;
                    oPC_we    = cls_q == CL_BRANCH;
                    oPC_sel   = (cls_q == CL_BRANCH && iBr_taken) ? PC_IMM : PC_PLUS4;
                end
                MEM: begin
                    oImm_type     = imm_q;
                    oMem_req      = 1'b1;
                    oMem_addr_sel = 1'b1;
                    oMem_we       = cls_q == CL_STORE;
                    oPC_we        = cls_q == CL_STORE && iMem_ready;
                end
                WB: begin
                    oImm_type = imm_q;
                    oReg_we   = 1'b1;
                    oWb_sel   = (cls_q == CL_LOAD) ? WB_MEM :
                                (cls_q == CL_JAL || cls_q == CL_JALR) ? WB_PC4 : WB_ALU;
                    oPC_we    = 1'b1;
                    oPC_sel   = (cls_q == CL_JAL) ? PC_IMM :
                                (cls_q == CL_JALR) ? PC_RS1 : PC_PLUS4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven and directed checks of the multi-cycle control FSM
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [4:0] imm;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       req;
        logic       we;
        logic       asel;
        logic       sa;
        logic       sb;
        logic [1:0] op;
        logic       rwe;
        logic [1:0] wsel;
        logic       trap;
        logic [1:0] cause;
    } out_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        rdy;
        logic        br;
        out_t        exp;
    } vec_t;

    localparam int WAIT_MAX = 16;
    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] SW    = 32'h00112223;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] JAL   = 32'h008000EF;
    localparam logic [31:0] JALR  = 32'h000080E7;
    localparam logic [31:0] LUI   = 32'h123450B7;
    localparam logic [31:0] AUIPC = 32'h00001097;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] LW    = 32'h0000A103;
    localparam logic [31:0] BAD   = 32'h0000007F;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [31:0] iInstruction = '0;
    logic        iMem_ready = 1'b0;
    logic        iBr_taken = 1'b0;
    logic [4:0]  oImm_type;
    logic        oIR_we, oPC_we, oMem_req, oMem_we, oMem_addr_sel;
    logic        oALU_srcA, oALU_srcB, oReg_we, oTrap;
    logic [1:0]  oPC_sel, oALU_op, oWb_sel, oCause;
    out_t        act;
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs[$];

    multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iInstruction  (iInstruction),
        .iMem_ready    (iMem_ready),
        .iBr_taken     (iBr_taken),
        .oImm_type     (oImm_type),
        .oIR_we        (oIR_we),
        .oPC_we        (oPC_we),
        .oPC_sel       (oPC_sel),
        .oMem_req      (oMem_req),
        .oMem_we       (oMem_we),
        .oMem_addr_sel (oMem_addr_sel),
        .oALU_srcA     (oALU_srcA),
        .oALU_srcB     (oALU_srcB),
        .oALU_op       (oALU_op),
        .oReg_we       (oReg_we),
        .oWb_sel       (oWb_sel),
        .oTrap         (oTrap),
        .oCause        (oCause)
    );

    assign act = {oImm_type, oIR_we, oPC_we, oPC_sel, oMem_req, oMem_we, oMem_addr_sel,
                  oALU_srcA, oALU_srcB, oALU_op, oReg_we, oWb_sel, oTrap, oCause};

    always #5 iClk = ~iClk;

    function automatic out_t o(input logic [4:0] imm, input logic irwe, input logic pcwe,
                               input logic [1:0] pcsel, input logic req, input logic we,
                               input logic asel, input logic sa, input logic sb,
                               input logic [1:0] op, input logic rwe, input logic [1:0] wsel,
                               input logic trap, input logic [1:0] cause);
        return {imm, irwe, pcwe, pcsel, req, we, asel, sa, sb, op, rwe, wsel, trap, cause};
    endfunction

    task automatic check(input string name, input out_t e);
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, e);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic rdy, input logic br);
        iInstruction = ins;
        iMem_ready   = rdy;
        iBr_taken    = br;
        @(negedge iClk);
    endtask

    task automatic next_cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst       = 1'b1;
        iMem_ready = 1'b0;
        iBr_taken  = 1'b0;
        #1;
        check("reset_zero", '0);
        next_cycle();
        iRst = 1'b0;
    endtask

    task automatic add(input logic [31:0] ins, input logic rdy, input logic br, input out_t e);
        vecs.push_back({ins, rdy, br, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t z, fr, fw, lw_ex, lw_mem, trap_to, trap_ill;
        z        = '0;
        fr       = o(5'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fw       = o(5'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw_ex    = o(5'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        lw_mem   = o(5'd1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        trap_to  = o(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10);
        trap_ill = o(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01);

        // ADDI, zero-wait; ready/branch inputs in non-request states must be ignored
        add(ADDI, 1, 0, fr);
        add(ADDI, 1, 1, z);
        add(ADDI, 1, 1, o(5'd1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        add(ADDI, 1, 1, o(5'd1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // SW with one fetch wait and ack after 3 memory wait cycles
        add(SW, 0, 0, fw);
        add(SW, 1, 0, fr);
        add(SW, 0, 0, z);
        add(SW, 0, 0, o(5'd2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add(SW, 0, 0, o(5'd2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(SW, 0, 0, o(5'd2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(SW, 0, 0, o(5'd2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(SW, 1, 0, o(5'd2, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        // BEQ taken, then not taken
        add(BEQ, 1, 0, fr);
        add(BEQ, 0, 0, z);
        add(BEQ, 0, 1, o(5'd4, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        add(BEQ, 1, 0, fr);
        add(BEQ, 0, 1, z);
        add(BEQ, 0, 0, o(5'd4, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        // JAL
        add(JAL, 1, 0, fr);
        add(JAL, 0, 0, z);
        add(JAL, 0, 0, o(5'd16, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        add(JAL, 0, 0, o(5'd16, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        // JALR
        add(JALR, 1, 0, fr);
        add(JALR, 0, 0, z);
        add(JALR, 0, 0, o(5'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add(JALR, 0, 0, o(5'd1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        // LUI
        add(LUI, 1, 0, fr);
        add(LUI, 0, 0, z);
        add(LUI, 0, 0, o(5'd8, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
        add(LUI, 0, 0, o(5'd8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // AUIPC
        add(AUIPC, 1, 0, fr);
        add(AUIPC, 0, 0, z);
        add(AUIPC, 0, 0, o(5'd8, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        add(AUIPC, 0, 0, o(5'd8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // ADD (register-register)
        add(ADD, 1, 0, fr);
        add(ADD, 0, 0, z);
        add(ADD, 0, 0, o(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        add(ADD, 0, 0, o(5'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // LW with one memory wait
        add(LW, 1, 0, fr);
        add(LW, 0, 0, z);
        add(LW, 0, 0, lw_ex);
        add(LW, 0, 0, lw_mem);
        add(LW, 1, 0, lw_mem);
        add(LW, 0, 0, o(5'd1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));

        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i].instr, vecs[i].rdy, vecs[i].br);
            check($sformatf("vec%0d", i), vecs[i].exp);
            next_cycle();
        end

        // async reset in the middle of a LOAD's MEM phase
        apply(LW, 1, 0); check("lw_fetch", fr); next_cycle();
        apply(LW, 0, 0); check("lw_decode", z); next_cycle();
        apply(LW, 0, 0); check("lw_exec", lw_ex); next_cycle();
        apply(LW, 0, 0); check("lw_mem_wait", lw_mem);
        #2;
        iRst = 1'b1;
        #1;
        check("rst_mid_mem", z);
        next_cycle();
        check("rst_held", z);
        iRst = 1'b0;
        apply(32'h0, 0, 0); check("rst_release_fetch", fw);

        // FETCH timeout after WAIT_MAX unacknowledged cycles
        do_reset();
        for (int i = 0; i < WAIT_MAX; i++) begin
            apply(32'h0, 0, 0);
            check($sformatf("fetch_wait%0d", i), fw);
            next_cycle();
        end
        apply(ADDI, 1, 1); check("fetch_timeout", trap_to); next_cycle();
        apply(ADDI, 1, 1); check("timeout_sticky", trap_to);

        // ready on the last allowed cycle wins, then MEM timeout on a LOAD
        do_reset();
        for (int i = 0; i < WAIT_MAX - 1; i++) begin
            apply(ADDI, 0, 0);
            next_cycle();
        end
        apply(ADDI, 1, 0); check("fetch_last_ready", fr); next_cycle();
        apply(ADDI, 0, 0); check("no_trap_decode", z); next_cycle();
        apply(ADDI, 0, 0); check("late_addi_exec", o(5'd1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0)); next_cycle();
        apply(ADDI, 0, 0); next_cycle();
        apply(LW, 1, 0); next_cycle();
        apply(LW, 0, 0); next_cycle();
        apply(LW, 0, 0); next_cycle();
        for (int i = 0; i < WAIT_MAX; i++) begin
            apply(LW, 0, 0);
            if (i == WAIT_MAX - 1) check("mem_wait_last", lw_mem);
            next_cycle();
        end
        apply(LW, 1, 0); check("mem_timeout", trap_to);

        // illegal opcode traps and stays trapped until reset
        do_reset();
        apply(BAD, 1, 0); check("bad_fetch", fr); next_cycle();
        apply(BAD, 0, 0); check("bad_decode", z); next_cycle();
        for (int i = 0; i < 3; i++) begin
            apply(ADDI, 1, 1);
            check($sformatf("illegal_trap%0d", i), trap_ill);
            next_cycle();
        end
        do_reset();
        apply(32'h0, 0, 0); check("reset_exits_trap", fw);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
